char_seq_ctrl: RTL and testbench
================================

CHAR_SEQ_CTRL -- requirements
Module: char_seq_ctrl

Interface
REQ-001 Parameter DWELL_W, default 20, width of the dwell counter and the dwell input.
REQ-002 Parameter SEQ_LEN, default 4, number of sequence slots; legal values 2..4.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level; a run is requested when high in IDLE.
REQ-006 stop  input  1  level; aborts the run in progress.
REQ-007 dwell  input  DWELL_W  clk cycles each character is held; sampled on run start.
REQ-008 slow_en_cfg  input  1  requested slow-clock mode for the run; sampled on run start.
REQ-009 seq_wr_en  input  1  sequence-table write strobe.
REQ-010 seq_wr_addr  input  2  table slot to write.
REQ-011 seq_wr_data  input  2  character code: 00 A, 01 J, 10 N, 11 X.
REQ-012 char_select  output  2  character code driven to the character PWM generator.
REQ-013 slow_clk_en  output  1  slow-clock enable driven to the character PWM generator.
REQ-014 seq_idx  output  2  current table slot.
REQ-015 busy  output  1  high while in RUN.
REQ-016 done  output  1  one-cycle pulse on normal run completion.

Function
REQ-017 FSM states: IDLE, RUN, DONE; all outputs registered.
REQ-018 IDLE->RUN when start=1 and stop=0; the same edge loads dwell (0 treated as 1), latches slow_en_cfg, sets seq_idx=0, char_select=table[0], and clears the dwell counter.
REQ-019 In RUN, the dwell counter increments each cycle; on reaching dwell_latched-1 the counter clears and seq_idx advances, with char_select=table[seq_idx+1] on the following cycle; each character is visible for exactly dwell_latched cycles.
REQ-020 On expiry of slot SEQ_LEN-1 without looping: RUN->DONE, with done=1 for exactly that cycle; DONE->IDLE unconditionally on the next cycle.
REQ-021 stop=1 in RUN: -> IDLE next cycle with no done pulse; stop has priority over dwell expiry in the same cycle.
REQ-022 In IDLE and DONE: char_select=00, slow_clk_en=0, seq_idx=0, busy=0.
REQ-023 In RUN: busy=1 and slow_clk_en equals the latched slow_en_cfg.
REQ-024 Table writes are accepted only when busy=0; writes while busy are dropped silently.
REQ-025 Writes to addresses >= SEQ_LEN are dropped.
REQ-026 start held high continuously re-launches a run one cycle after each DONE.
REQ-027 The dwell counter saturates at the width of DWELL_W; there is no wrap-induced early advance.

Reset
REQ-028 rst=1 forces IDLE, all outputs to 0, and the dwell counter to 0; the table resets to slot0=00, slot1=01, slot2=10, slot3=11.
REQ-029 rst asserted mid-run aborts the run at the next edge; no done pulse is generated.

Configuration
REQ-030 Macro CHAR_SEQ_LOOP_EN defined: adds input port loop (1 bit); if loop=1 at slot SEQ_LEN-1 expiry, seq_idx wraps to 0 and the FSM stays in RUN with no done pulse.
REQ-031 Macro CHAR_SEQ_LOOP_EN undefined: the loop port is absent; every run ends via DONE.

Structure
REQ-032 Shared package char_pkg holds the character code constants (CHAR_A, CHAR_J, CHAR_N, CHAR_X), the FSM state encodings, and the reset table contents.
REQ-033 One sub-module, char_dwell_timer (load, count, expire pulse), is instantiated once; the remainder is flat.

Verification
REQ-034 Reset then start=1 for 1 cycle, dwell=3 -> char_select 00,01,10,11 each for 3 cycles, then done=1 for 1 cycle, then IDLE.
REQ-035 Write table to 11,11,00,01 in IDLE, run with dwell=1 -> char_select sequence 11,11,00,01 on consecutive cycles; done on the 5th cycle.
REQ-036 stop=1 on the 2nd cycle of slot 1 -> busy=0 next cycle, char_select=00, done never asserted.
REQ-037 seq_wr_en during RUN at slot 2 -> table unchanged; the next run still shows the prior slot 2 code.
REQ-038 dwell=0, slow_en_cfg=1 -> each slot lasts 1 cycle and slow_clk_en=1 exactly while busy=1.
REQ-039 CHAR_SEQ_LOOP_EN with loop=1, dwell=2 -> seq_idx pattern 0,0,1,1,2,2,3,3,0,0 with no done; rst mid-run -> IDLE next cycle.

Source files
------------

// File: rtl/char_pkg.sv
// Shared definitions for the character sequencer: character codes,
// FSM state encoding and the power-on contents of the sequence table.
package char_pkg;

  localparam logic [1:0] CHAR_A = 2'b00;
  localparam logic [1:0] CHAR_J = 2'b01;
  localparam logic [1:0] CHAR_N = 2'b10;
  localparam logic [1:0] CHAR_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Slot i resets to the i-th entry, slot 0 in the low bits.
  localparam logic [7:0] RST_TBL = {CHAR_X, CHAR_N, CHAR_J, CHAR_A};

  function automatic logic [1:0] rst_char(input logic [1:0] slot);
    return RST_TBL[2*slot +: 2];
  endfunction

endpackage

// File: rtl/char_dwell_timer.sv
// Dwell timer: loads the per-run dwell (0 promoted to 1), counts while
// enabled and flags the last cycle of each dwell period.
module char_dwell_timer #(
  parameter int DWELL_W = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               en,
  output logic               expire
);

  logic [DWELL_W-1:0] dwell_d, dwell_q;
  logic [DWELL_W-1:0] cnt_d, cnt_q;

  assign expire = en && (cnt_q == (dwell_q - DWELL_W'(1)));

  // Next dwell/counter values; the counter holds at all-ones rather than wrapping.
  always_comb begin
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    if (load) begin
      dwell_d = (load_val == '0) ? DWELL_W'(1) : load_val;
      cnt_d   = '0;
    end else if (en) begin
      if (expire)
        cnt_d = '0;
      else if (cnt_q != '1)
        cnt_d = cnt_q + DWELL_W'(1);
    end
  end

  // Timer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q <= '0;
      cnt_q   <= '0;
    end else begin
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/char_seq_ctrl.sv
// Character sequencer: steps a small table of character codes out to the
// character PWM generator, holding each for a programmable dwell.
// Optional macro CHAR_SEQ_LOOP_EN adds a 'loop' input that restarts the
// sequence at slot 0 instead of finishing.
//
// state | meaning
// IDLE  | waiting for start, table writable, outputs zero
// RUN   | stepping through slots, busy high
// DONE  | one-cycle completion pulse, then back to IDLE
module char_seq_ctrl
  import char_pkg::*;
#(
  parameter int DWELL_W = 20,
  parameter int SEQ_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               slow_en_cfg,
  input  logic               seq_wr_en,
  input  logic [1:0]         seq_wr_addr,
  input  logic [1:0]         seq_wr_data,
`ifdef CHAR_SEQ_LOOP_EN
  input  logic               loop,
`endif
  output logic [1:0]         char_select,
  output logic               slow_clk_en,
  output logic [1:0]         seq_idx,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] LAST_IDX = 2'(SEQ_LEN - 1);

  state_e     state_d, state_q;
  logic [1:0] char_d, char_q;
  logic       slow_d, slow_q;
  logic [1:0] idx_d, idx_q;
  logic       busy_d, busy_q;
  logic       done_d, done_q;
  logic [1:0] tbl_d [4];
  logic [1:0] tbl_q [4];
  logic       launch;
  logic       expire;
  logic       loop_req;
  logic [1:0] idx_inc;

`ifdef CHAR_SEQ_LOOP_EN
  assign loop_req = loop;
`else
  assign loop_req = 1'b0;
`endif

  assign idx_inc = idx_q + 2'd1;

  char_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (launch),
    .load_val (dwell),
    .en       (state_q == ST_RUN),
    .expire   (expire)
  );

  // Table write path: only while not busy and only to implemented slots.
  always_comb begin
    tbl_d = tbl_q;
    if (seq_wr_en && !busy_q && (seq_wr_addr <= LAST_IDX))
      tbl_d[seq_wr_addr] = seq_wr_data;
  end

  // Next state and next registered outputs; stop outranks dwell expiry.
  always_comb begin
    state_d = state_q;
    char_d  = CHAR_A;
    slow_d  = 1'b0;
    idx_d   = 2'd0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    launch  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          launch  = 1'b1;
          state_d = ST_RUN;
          busy_d  = 1'b1;
          slow_d  = slow_en_cfg;
          char_d  = tbl_q[0];
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          busy_d = 1'b1;
          slow_d = slow_q;
          idx_d  = idx_q;
          char_d = char_q;
          if (expire) begin
            if (idx_q != LAST_IDX) begin
              idx_d  = idx_inc;
              char_d = tbl_q[idx_inc];
            end else if (loop_req) begin
              idx_d  = 2'd0;
              char_d = tbl_q[0];
            end else begin
              state_d = ST_DONE;
              busy_d  = 1'b0;
              slow_d  = 1'b0;
              idx_d   = 2'd0;
              char_d  = CHAR_A;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, output and table registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      char_q  <= CHAR_A;
      slow_q  <= 1'b0;
      idx_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 4; i++) tbl_q[i] <= rst_char(2'(i));
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      slow_q  <= slow_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tbl_q   <= tbl_d;
    end
  end

  assign char_select = char_q;
  assign slow_clk_en = slow_q;
  assign seq_idx     = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_char_seq_ctrl.sv
// Scoreboard bench for char_seq_ctrl: each run pushes its expected
// per-cycle output trace; a negedge monitor pops and compares whenever
// busy or done is high and checks all-zero outputs otherwise.
module tb_char_seq_ctrl;

  localparam int DW = 20;
  localparam int SL = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stop;
  logic [DW-1:0] dwell;
  logic          slow_en_cfg;
  logic          seq_wr_en;
  logic [1:0]    seq_wr_addr;
  logic [1:0]    seq_wr_data;
  logic [1:0]    char_select;
  logic          slow_clk_en;
  logic [1:0]    seq_idx;
  logic          busy;
  logic          done;
`ifdef CHAR_SEQ_LOOP_EN
  logic          loop;
  initial loop = 1'b0;
`endif

  char_seq_ctrl #(.DWELL_W(DW), .SEQ_LEN(SL)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .dwell       (dwell),
    .slow_en_cfg (slow_en_cfg),
    .seq_wr_en   (seq_wr_en),
    .seq_wr_addr (seq_wr_addr),
    .seq_wr_data (seq_wr_data),
`ifdef CHAR_SEQ_LOOP_EN
    .loop        (loop),
`endif
    .char_select (char_select),
    .slow_clk_en (slow_clk_en),
    .seq_idx     (seq_idx),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ch;
    logic       slow;
    logic [1:0] idx;
    logic       bsy;
    logic       dn;
  } obs_t;

  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  obs_t exp_q[$];
  obs_t mon_a, mon_e;
  logic [1:0] tbl_m [4];

  // Monitor: compare every active output cycle against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_a = {char_select, slow_clk_en, seq_idx, busy, done};
      total++;
      if (busy || done) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_active got=%b required=idle t=%0t", mon_a, $time);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_a !== mon_e) begin
            bad++;
            $display("FAIL trace got=%b required=%b t=%0t", mon_a, mon_e, $time);
          end
        end
      end else if (mon_a !== '0) begin
        bad++;
        $display("FAIL idle_outputs got=%b required=0000000 t=%0t", mon_a, $time);
      end
    end
  end

  task automatic model_reset_tbl();
    tbl_m[0] = 2'b00; tbl_m[1] = 2'b01; tbl_m[2] = 2'b10; tbl_m[3] = 2'b11;
  endtask

  // Expected trace of a run truncated to ncyc RUN cycles (ncyc<0: complete).
  task automatic push_run(input int d, input bit s, input int ncyc);
    int deff;
    int cnt;
    deff = (d == 0) ? 1 : d;
    cnt  = 0;
    for (int slot = 0; slot < SL; slot++)
      for (int r = 0; r < deff; r++) begin
        if (ncyc < 0 || cnt < ncyc) exp_q.push_back({tbl_m[slot], s, 2'(slot), 1'b1, 1'b0});
        cnt++;
      end
    if (ncyc < 0) exp_q.push_back({2'b00, 1'b0, 2'b00, 1'b0, 1'b1});
  endtask

  task automatic check_drained(input string tag);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drained got=%0d pending required=0", tag, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic wr(input logic [1:0] a, input logic [1:0] dt);
    seq_wr_en = 1'b1; seq_wr_addr = a; seq_wr_data = dt;
    @(posedge clk); #1;
    seq_wr_en = 1'b0;
    if (int'(a) < SL) tbl_m[a] = dt;
  endtask

  // One run; cut>0 aborts during RUN cycle 'cut' via stop (or rst if use_rst).
  // Garbage table writes and input changes are thrown at the DUT while busy.
  task automatic do_run(input int d, input bit s, input int cut, input bit use_rst);
    int len;
    int n;
    len = SL * ((d == 0) ? 1 : d);
    n   = (cut > 0) ? cut : len;
    push_run(d, s, (cut > 0) ? cut : -1);
    start = 1'b1; dwell = DW'(d); slow_en_cfg = s;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= n; c++) begin
      dwell       = DW'($urandom_range(0, 7));
      slow_en_cfg = 1'($urandom);
      seq_wr_en   = 1'($urandom);
      seq_wr_addr = 2'($urandom);
      seq_wr_data = 2'($urandom);
      if (c == n && cut > 0) begin
        if (use_rst) rst = 1'b1; else stop = 1'b1;
      end
      @(posedge clk); #1;
    end
    stop = 1'b0; rst = 1'b0; seq_wr_en = 1'b0;
    if (cut > 0 && use_rst) model_reset_tbl();
    if (cut == 0) begin
      @(posedge clk); #1;
    end
    check_drained("run");
  endtask

  // start held high across a DONE: a second run follows after one IDLE cycle.
  task automatic relaunch(input int d);
    int len;
    len = SL * d;
    push_run(d, 1'b0, -1);
    push_run(d, 1'b0, -1);
    start = 1'b1; dwell = DW'(d); slow_en_cfg = 1'b0;
    repeat (len + 3) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (len + 1) begin
      @(posedge clk); #1;
    end
    check_drained("relaunch");
  endtask

  initial begin
    int d, cut;
    bit s, ur;
    rst = 1'b1; start = 1'b0; stop = 1'b0; dwell = '0; slow_en_cfg = 1'b0;
    seq_wr_en = 1'b0; seq_wr_addr = 2'b00; seq_wr_data = 2'b00;
    model_reset_tbl();
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // stop while idle must not launch
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    @(posedge clk); #1;

    do_run(3, 1'b0, 0, 1'b0);
    wr(2'd0, 2'b11); wr(2'd1, 2'b11); wr(2'd2, 2'b00); wr(2'd3, 2'b01);
    do_run(1, 1'b0, 0, 1'b0);
    do_run(3, 1'b0, 5, 1'b0);
    do_run(0, 1'b1, 0, 1'b0);
    do_run(2, 1'b0, 0, 1'b0);
    relaunch(2);
    do_run(2, 1'b1, 3, 1'b1);
    do_run(1, 1'b0, 0, 1'b0);

    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(0, 2)) wr(2'($urandom), 2'($urandom));
      d  = $urandom_range(0, 5);
      s  = 1'($urandom);
      ur = ($urandom_range(0, 7) == 0);
      cut = 0;
      if ($urandom_range(0, 2) == 0) cut = $urandom_range(1, SL * ((d == 0) ? 1 : d));
      do_run(d, s, cut, ur && (cut > 0));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
